dcache_miss_ctrl: RTL and testbench
===================================

# dcache_miss_ctrl

Miss handler sitting directly downstream of the two-way DCache data/tag unit. It consumes the unit's registered-stage lookup result (hit, replace_way, dirty). On a miss it:
- writes back the dirty victim line;
- refills the line from memory as a 4-beat 32-bit burst;
- installs the line through the unit's update port;
- signals the pipeline to replay the access.

It stalls the LSU front end while busy.

## Interface
Parameters:
- LINE_BEATS, 4, 32-bit beats per 128-bit line (fixed at 4; other values unsupported)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
- lk_valid  in  1  lookup result stage valid (read or write access in P1)
- lk_addr  in  32  P1 access address
- lk_hit  in  1  cache hit
- lk_replace_way  in  1  victim way, valid when lk_hit=0
- lk_dirty  in  1  victim dirty bit, valid when lk_hit=0
- stall  out  1  front end must hold and not issue
- replay  out  1  one-cycle pulse: re-issue the missed access
- wb_ena  out  1  one-cycle pulse: clear victim dirty bit
- wb_addr  out  32  victim line address {victim_tag, index, 4'b0}
- wb_way  out  1  victim way
- wb_line  in  128  victim line, combinational from wb_addr/wb_way
- victim_tag  in  20  tag of replace way at P1 index (combinational from unit)
- upd_ena  out  1  one-cycle pulse: install refilled line
- upd_way  out  1  install way
- upd_addr  out  32  install address
- upd_line  out  128  install data
- mem_rd_req  out  1  read request, held until mem_rd_gnt
- mem_rd_addr  out  32  line-aligned read address
- mem_rd_gnt  in  1  read request accepted
- mem_rd_valid  in  1  read beat valid
- mem_rd_data  in  32  read beat
- mem_wr_req  out  1  write request, held until mem_wr_gnt
- mem_wr_addr  out  32  line-aligned write address
- mem_wr_gnt  in  1  write request accepted
- mem_wr_valid  out  1  write beat valid
- mem_wr_data  out  32  write beat
- mem_wr_ready  in  1  write beat accepted
- mem_wr_done  in  1  write burst complete response

## Operation
- State encoding: IDLE, WB_REQ, WB_DATA, WB_WAIT, RF_REQ, RF_DATA, INSTALL, REPLAY.
- **IDLE**
  - lk_valid=1 && lk_hit=0 → latch miss_addr, victim way and victim_tag; assert stall combinationally in the same cycle.
  - If lk_dirty=1: pulse wb_ena and capture wb_line into a 128-bit wb_buf at this edge, then → WB_REQ.
  - Otherwise → RF_REQ.
- **WB_REQ**: mem_wr_req=1 with wb_addr; → WB_DATA on gnt; beat counter cleared.
- **WB_DATA**
  - mem_wr_valid=1, data = wb_buf[cnt*32 +: 32]; cnt++ on ready.
  - Beat 3 accepted → WB_WAIT.
- **WB_WAIT**: → RF_REQ on mem_wr_done.
- **RF_REQ**: mem_rd_req=1 with {miss_addr[31:4], 4'b0}; → RF_DATA on gnt; cnt cleared.
- **RF_DATA**
  - Each mem_rd_valid writes rf_buf[cnt*32 +: 32]; cnt++.
  - Beat 3 → INSTALL.
  - Beats arrive in ascending word order, no critical-word-first.
- **INSTALL**: upd_ena=1 for exactly one cycle with way, miss_addr line-aligned and rf_buf; → REPLAY.
- **REPLAY**: replay=1 for one cycle; stall deasserts in this cycle; → IDLE.
- stall=1 in every state except IDLE; in IDLE it equals lk_valid && !lk_hit.
- Hits in IDLE: no action, no outputs.
- lk_valid while not IDLE is ignored; the front end is stalled, so it is a protocol error.
- Counter is 2 bits and wraps 3→0; the wrap is the end-of-burst condition.
- Store miss: only the line is installed. The store completes via replay as a write hit. No write-allocate merge here.

## Timing
- Reset values:
  - state IDLE; cnt 0; buffers X-don't-care.
  - Outputs 0: stall (IDLE output is then combinational from inputs), replay, wb_ena, upd_ena, mem_rd_req, mem_wr_req, mem_wr_valid.
- Reset mid-burst: abandon immediately and return to IDLE. The memory side is reset in the same domain.
- Clean-miss latency, zero-wait memory: detect (T0) → RF_REQ T1 → gnt T1 → beats T2–T5 → INSTALL T6 → REPLAY T7.
- Dirty miss adds WB_REQ (1) + 4 beats + ≥1 WB_WAIT.
- mem_rd_valid ignored outside RF_DATA; mem_wr_done ignored outside WB_WAIT.
- Request and addresses held stable until gnt.
- upd_ena and replay are never in the same cycle, so the replayed lookup sees installed data.

## Structure
- Package dcache_pkg:
  - state enum `dcache_miss_state_t`;
  - LINE_BYTES=16, OFFSET_W=4, INDEX_W=8, TAG_W=20;
  - helper for line-aligning an address.
- One sub-module is natural: `line_beat_buf`, a 128-bit buffer with a 2-bit beat counter and load/shift-select. Instantiate it twice: write-back serialiser and refill deserialiser.

## Test plan
- Clean read miss at 0x0000_1234, way0 invalid, beats 0x11,0x22,0x33,0x44 → mem_rd_addr=0x0000_1230; upd_line=0x00000044_00000033_00000022_00000011, upd_way=0; replay 1 cycle after upd_ena.
- Dirty miss, victim_tag=0xABCDE, index 0x23, way1 → wb_ena pulse at T0 with wb_addr=0xABCDE230; four write beats from wb_buf low word first; refill issued only after mem_wr_done.
- mem_wr_ready low for 3 cycles on beat 2 → mem_wr_data holds beat 2; exactly 4 beats total.
- Hit (lk_hit=1) in IDLE → stall=0, no memory request, no pulses.
- rst asserted during RF_DATA beat 2 → next cycle state IDLE, all outputs 0, no upd_ena.
- Back-to-back misses (second miss presented at cycle after REPLAY) → second handled fully; no lost or duplicated upd_ena.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, line geometry and address helpers for the DCache miss path
package dcache_pkg;

  localparam int LINE_BYTES = 16;
  localparam int OFFSET_W   = 4;
  localparam int INDEX_W    = 8;
  localparam int TAG_W      = 20;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_DATA,
    WB_WAIT,
    RF_REQ,
    RF_DATA,
    INSTALL,
    REPLAY
  } dcache_miss_state_t;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~32'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/line_beat_buf.sv
// rtl/line_beat_buf.sv - line buffer with a wrapping beat counter, used as serialiser or deserialiser
module line_beat_buf #(
  parameter int BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [BEATS*32-1:0]   i_line,
  input  logic                  i_beat_we,
  input  logic [31:0]           i_beat_data,
  input  logic                  i_cnt_clr,
  input  logic                  i_cnt_inc,
  output logic [BEATS*32-1:0]   o_line,
  output logic [31:0]           o_beat,
  output logic                  o_last
);

  localparam int CNT_W = $clog2(BEATS);

  logic [BEATS*32-1:0] r_line;
  logic [CNT_W-1:0]    r_cnt;

  // The counter wraps naturally after the last beat, which doubles as end-of-burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_cnt <= '0;
    end else if (i_cnt_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_line <= i_line;
    end else if (i_beat_we) begin
      for (int b = 0; b < BEATS; b++) begin
        if (r_cnt == CNT_W'(b)) begin
          r_line[b*32 +: 32] <= i_beat_data;
        end
      end
    end
  end

  always_comb begin
    o_beat = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (r_cnt == CNT_W'(b)) begin
        o_beat = r_line[b*32 +: 32];
      end
    end
  end

  assign o_line = r_line;
  assign o_last = (r_cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/dcache_miss_ctrl.sv
// rtl/dcache_miss_ctrl.sv - two-way DCache miss handler: victim write-back, line refill, install, replay
module dcache_miss_ctrl
  import dcache_pkg::*;
#(
  parameter int LINE_BEATS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lk_valid,
  input  logic [31:0]        lk_addr,
  input  logic               lk_hit,
  input  logic               lk_replace_way,
  input  logic               lk_dirty,
  output logic               stall,
  output logic               replay,
  output logic               wb_ena,
  output logic [31:0]        wb_addr,
  output logic               wb_way,
  input  logic [127:0]       wb_line,
  input  logic [TAG_W-1:0]   victim_tag,
  output logic               upd_ena,
  output logic               upd_way,
  output logic [31:0]        upd_addr,
  output logic [127:0]       upd_line,
  output logic               mem_rd_req,
  output logic [31:0]        mem_rd_addr,
  input  logic               mem_rd_gnt,
  input  logic               mem_rd_valid,
  input  logic [31:0]        mem_rd_data,
  output logic               mem_wr_req,
  output logic [31:0]        mem_wr_addr,
  input  logic               mem_wr_gnt,
  output logic               mem_wr_valid,
  output logic [31:0]        mem_wr_data,
  input  logic               mem_wr_ready,
  input  logic               mem_wr_done
);

  dcache_miss_state_t r_state;
  logic [31:0]  r_miss_addr;
  logic [31:0]  r_wb_addr;
  logic         r_way;
  logic         r_stall;
  logic         r_replay;
  logic         r_upd_ena;
  logic         r_mem_rd_req;
  logic         r_mem_wr_req;
  logic         r_mem_wr_valid;

  logic         w_idle;
  logic         w_miss;
  logic [31:0]  w_idle_wb_addr;
  logic         w_wr_accept;
  logic         w_rd_beat;
  logic         w_wb_last;
  logic         w_rf_last;
  logic [31:0]  w_wb_beat;
  logic [127:0] w_rf_line;
  logic [127:0] w_wb_line_unused;
  logic [31:0]  w_rf_beat_unused;

  assign w_idle         = (r_state == IDLE);
  assign w_miss         = w_idle && lk_valid && !lk_hit;
  assign w_idle_wb_addr = {victim_tag, lk_addr[OFFSET_W +: INDEX_W], {OFFSET_W{1'b0}}};
  assign w_wr_accept    = (r_state == WB_DATA) && mem_wr_ready;
  assign w_rd_beat      = (r_state == RF_DATA) && mem_rd_valid;

  // Victim address must be live in the detect cycle so the unit can return wb_line combinationally.
  assign wb_ena  = w_miss && lk_dirty;
  assign wb_addr = w_idle ? w_idle_wb_addr : r_wb_addr;
  assign wb_way  = w_idle ? lk_replace_way : r_way;
  assign stall   = w_idle ? w_miss : r_stall;

  assign replay       = r_replay;
  assign upd_ena      = r_upd_ena;
  assign upd_way      = r_way;
  assign upd_addr     = r_miss_addr;
  assign upd_line     = w_rf_line;
  assign mem_rd_req   = r_mem_rd_req;
  assign mem_rd_addr  = r_miss_addr;
  assign mem_wr_req   = r_mem_wr_req;
  assign mem_wr_addr  = r_wb_addr;
  assign mem_wr_valid = r_mem_wr_valid;
  assign mem_wr_data  = w_wb_beat;

  line_beat_buf #(.BEATS(LINE_BEATS)) u_wb_buf (
    .clk         (clk),
    .rst         (rst),
    .i_load      (wb_ena),
    .i_line      (wb_line),
    .i_beat_we   (1'b0),
    .i_beat_data (32'h0),
    .i_cnt_clr   ((r_state == WB_REQ) && mem_wr_gnt),
    .i_cnt_inc   (w_wr_accept),
    .o_line      (w_wb_line_unused),
    .o_beat      (w_wb_beat),
    .o_last      (w_wb_last)
  );

  line_beat_buf #(.BEATS(LINE_BEATS)) u_rf_buf (
    .clk         (clk),
    .rst         (rst),
    .i_load      (1'b0),
    .i_line      (128'h0),
    .i_beat_we   (w_rd_beat),
    .i_beat_data (mem_rd_data),
    .i_cnt_clr   ((r_state == RF_REQ) && mem_rd_gnt),
    .i_cnt_inc   (w_rd_beat),
    .o_line      (w_rf_line),
    .o_beat      (w_rf_beat_unused),
    .o_last      (w_rf_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_stall        <= 1'b0;
      r_replay       <= 1'b0;
      r_upd_ena      <= 1'b0;
      r_mem_rd_req   <= 1'b0;
      r_mem_wr_req   <= 1'b0;
      r_mem_wr_valid <= 1'b0;
    end else begin
      r_replay  <= 1'b0;
      r_upd_ena <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_miss_addr <= line_align(lk_addr);
            r_wb_addr   <= w_idle_wb_addr;
            r_way       <= lk_replace_way;
            r_stall     <= 1'b1;
            if (lk_dirty) begin
              r_mem_wr_req <= 1'b1;
              r_state      <= WB_REQ;
            end else begin
              r_mem_rd_req <= 1'b1;
              r_state      <= RF_REQ;
            end
          end
        end
        WB_REQ: begin
          if (mem_wr_gnt) begin
            r_mem_wr_req   <= 1'b0;
            r_mem_wr_valid <= 1'b1;
            r_state        <= WB_DATA;
          end
        end
        WB_DATA: begin
          if (w_wr_accept && w_wb_last) begin
            r_mem_wr_valid <= 1'b0;
            r_state        <= WB_WAIT;
          end
        end
        WB_WAIT: begin
          if (mem_wr_done) begin
            r_mem_rd_req <= 1'b1;
            r_state      <= RF_REQ;
          end
        end
        RF_REQ: begin
          if (mem_rd_gnt) begin
            r_mem_rd_req <= 1'b0;
            r_state      <= RF_DATA;
          end
        end
        RF_DATA: begin
          if (w_rd_beat && w_rf_last) begin
            r_upd_ena <= 1'b1;
            r_state   <= INSTALL;
          end
        end
        // Install and replay sit in separate cycles so the replayed lookup sees the new line.
        INSTALL: begin
          r_replay <= 1'b1;
          r_stall  <= 1'b0;
          r_state  <= REPLAY;
        end
        REPLAY: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb/tb_dcache_miss_ctrl.sv - randomized self-checking bench for dcache_miss_ctrl
module tb_dcache_miss_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         lk_valid;
  logic [31:0]  lk_addr;
  logic         lk_hit;
  logic         lk_replace_way;
  logic         lk_dirty;
  logic         stall;
  logic         replay;
  logic         wb_ena;
  logic [31:0]  wb_addr;
  logic         wb_way;
  logic [127:0] wb_line;
  logic [19:0]  victim_tag;
  logic         upd_ena;
  logic         upd_way;
  logic [31:0]  upd_addr;
  logic [127:0] upd_line;
  logic         mem_rd_req;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_gnt;
  logic         mem_rd_valid;
  logic [31:0]  mem_rd_data;
  logic         mem_wr_req;
  logic [31:0]  mem_wr_addr;
  logic         mem_wr_gnt;
  logic         mem_wr_valid;
  logic [31:0]  mem_wr_data;
  logic         mem_wr_ready;
  logic         mem_wr_done;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] salt = 32'h0;

  always #5 clk = ~clk;

  function automatic logic [127:0] victim_data(input logic [31:0] a, input logic w, input logic [31:0] s);
    return {a ^ 32'hA5A5_0003 ^ s, a ^ 32'h5A5A_0002, ~a ^ {31'b0, w}, a + {31'b0, w} + s};
  endfunction

  // Victim line depends on a salt that changes after detect, so only a detect-cycle capture is correct.
  assign wb_line = victim_data(wb_addr, wb_way, salt);

  dcache_miss_ctrl #(.LINE_BEATS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .lk_valid       (lk_valid),
    .lk_addr        (lk_addr),
    .lk_hit         (lk_hit),
    .lk_replace_way (lk_replace_way),
    .lk_dirty       (lk_dirty),
    .stall          (stall),
    .replay         (replay),
    .wb_ena         (wb_ena),
    .wb_addr        (wb_addr),
    .wb_way         (wb_way),
    .wb_line        (wb_line),
    .victim_tag     (victim_tag),
    .upd_ena        (upd_ena),
    .upd_way        (upd_way),
    .upd_addr       (upd_addr),
    .upd_line       (upd_line),
    .mem_rd_req     (mem_rd_req),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_gnt     (mem_rd_gnt),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_data    (mem_rd_data),
    .mem_wr_req     (mem_wr_req),
    .mem_wr_addr    (mem_wr_addr),
    .mem_wr_gnt     (mem_wr_gnt),
    .mem_wr_valid   (mem_wr_valid),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_ready   (mem_wr_ready),
    .mem_wr_done    (mem_wr_done)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem_inputs();
    mem_rd_gnt   = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = 32'h0;
    mem_wr_gnt   = 1'b0;
    mem_wr_ready = 1'b0;
    mem_wr_done  = 1'b0;
  endtask

  // mode 0: random waits and noise, 1: zero-wait memory, 2: zero-wait but beat 2 held off 3 cycles.
  task automatic run_miss(input logic [31:0] addr, input logic way, input logic dirty,
                          input logic [19:0] tag, input int mode, input int rst_beat,
                          input logic [127:0] refill);
    logic [31:0]  exp_wb_addr;
    logic [31:0]  exp_line_addr;
    logic [127:0] victim;
    logic [31:0]  wr_seen[$];
    int cyc, upd_cyc, upd_n, rep_n, rd_n, hold, stall_bad, quiet_bad;
    bit fin, rd_granted, done_sent, early_rd, aborted;

    exp_wb_addr   = {tag, addr[11:4], 4'h0};
    exp_line_addr = {addr[31:4], 4'h0};
    cyc = 0; upd_cyc = -10; upd_n = 0; rep_n = 0; rd_n = 0; hold = 0; stall_bad = 0;
    fin = 0; rd_granted = 0; done_sent = 0; early_rd = 0; aborted = 0;

    @(negedge clk);
    clear_mem_inputs();
    salt           = $urandom;
    lk_valid       = 1'b1;
    lk_hit         = 1'b0;
    lk_addr        = addr;
    lk_replace_way = way;
    lk_dirty       = dirty;
    victim_tag     = tag;
    #1;
    victim = victim_data(exp_wb_addr, way, salt);
    check_eq("detect_stall", stall, 1);
    check_eq("detect_wb_ena", wb_ena, dirty);
    if (dirty) begin
      check_eq("detect_wb_addr", wb_addr, exp_wb_addr);
      check_eq("detect_wb_way", wb_way, way);
    end

    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      clear_mem_inputs();
      salt           = $urandom;
      lk_valid       = (mode == 0) && ($urandom % 8 == 0);
      lk_hit         = 1'($urandom);
      lk_dirty       = 1'($urandom);
      lk_replace_way = 1'($urandom);
      lk_addr        = $urandom;
      victim_tag     = 20'($urandom);

      if (upd_ena) begin
        upd_n++;
        upd_cyc = cyc;
        check_eq("upd_addr", upd_addr, exp_line_addr);
        check_eq("upd_way", upd_way, way);
        check_eq("upd_line", upd_line, refill);
        check_eq("upd_after_4_beats", rd_n, 4);
      end
      if (replay) begin
        rep_n++;
        check_eq("replay_after_upd", cyc, upd_cyc + 1);
        check_eq("replay_stall_low", stall, 0);
        fin = 1;
      end else if (!stall) begin
        stall_bad++;
      end
      if (dirty && mem_rd_req && !done_sent) early_rd = 1;

      if (mem_wr_req) begin
        check_eq("mem_wr_addr", mem_wr_addr, exp_wb_addr);
        mem_wr_gnt = (mode != 0) || ($urandom % 3 == 0);
      end
      if (wr_seen.size() == 4 && !done_sent) begin
        mem_wr_done = (mode != 0) || ($urandom % 3 == 0);
        done_sent   = mem_wr_done;
      end else if (mode == 0 && !done_sent) begin
        mem_wr_done = ($urandom % 6 == 0);
      end
      if (mem_wr_valid) begin
        if (mode == 2 && wr_seen.size() == 2 && hold < 3) begin
          mem_wr_ready = 1'b0;
          check_eq("wr_hold_beat2", mem_wr_data, victim[95:64]);
          hold++;
        end else begin
          mem_wr_ready = (mode != 0) || ($urandom % 2 == 0);
          if (mem_wr_ready) wr_seen.push_back(mem_wr_data);
        end
      end

      if (rd_granted && rd_n < 4) begin
        if (rd_n == rst_beat) begin
          rst          = 1'b1;
          mem_rd_valid = 1'b1;
          mem_rd_data  = refill[rd_n*32 +: 32];
          aborted      = 1;
          fin          = 1;
        end else begin
          mem_rd_valid = (mode != 0) || ($urandom % 2 == 0);
          if (mem_rd_valid) begin
            mem_rd_data = refill[rd_n*32 +: 32];
            rd_n++;
          end
        end
      end else if (!rd_granted && mode == 0 && ($urandom % 4 == 0)) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'hDEAD_BEEF;
      end
      if (mem_rd_req) begin
        check_eq("mem_rd_addr", mem_rd_addr, exp_line_addr);
        mem_rd_gnt = (mode != 0) || ($urandom % 3 == 0);
        rd_granted = mem_rd_gnt;
      end
    end

    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      clear_mem_inputs();
      lk_valid = 1'b0;
      #1;
      check_eq("rst_stall", stall, 0);
      check_eq("rst_replay", replay, 0);
      check_eq("rst_upd_ena", upd_ena, 0);
      check_eq("rst_mem_rd_req", mem_rd_req, 0);
      check_eq("rst_mem_wr_req", mem_wr_req, 0);
      check_eq("rst_mem_wr_valid", mem_wr_valid, 0);
      quiet_bad = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'h0BAD_0000 + i;
        #1;
        if (upd_ena || replay || stall || mem_rd_req || mem_wr_req) quiet_bad++;
      end
      @(negedge clk);
      clear_mem_inputs();
      #1;
      if (upd_ena || replay || stall) quiet_bad++;
      check_eq("rst_quiet_after", quiet_bad, 0);
      return;
    end

    check_eq("miss_timeout", fin, 1);
    check_eq("upd_count", upd_n, 1);
    check_eq("replay_count", rep_n, 1);
    check_eq("stall_while_busy", stall_bad, 0);
    check_eq("wr_beat_count", wr_seen.size(), dirty ? 4 : 0);
    for (int i = 0; i < wr_seen.size() && i < 4; i++) begin
      check_eq($sformatf("wr_beat%0d", i), wr_seen[i], victim[i*32 +: 32]);
    end
    if (dirty) check_eq("rd_after_wr_done", early_rd, 0);
    if (mode == 1) check_eq("zero_wait_upd_cycle", upd_cyc, dirty ? 12 : 6);
    if (mode == 2) check_eq("wr_hold_cycles", hold, 3);
  endtask

  task automatic run_hits(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear_mem_inputs();
      lk_hit         = ($urandom % 3 != 0);
      lk_valid       = lk_hit;
      lk_addr        = $urandom;
      lk_dirty       = 1'($urandom);
      lk_replace_way = 1'($urandom);
      victim_tag     = 20'($urandom);
      #1;
      if (stall || wb_ena || replay || upd_ena || mem_rd_req || mem_wr_req || mem_wr_valid) bad++;
    end
    @(negedge clk);
    lk_valid = 1'b0;
    lk_hit   = 1'b0;
    #1;
    if (stall || wb_ena || replay || upd_ena || mem_rd_req || mem_wr_req || mem_wr_valid) bad++;
    check_eq("hit_quiet", bad, 0);
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst            = 1'b1;
    lk_valid       = 1'b0;
    lk_addr        = 32'h0;
    lk_hit         = 1'b0;
    lk_replace_way = 1'b0;
    lk_dirty       = 1'b0;
    victim_tag     = 20'h0;
    clear_mem_inputs();
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_stall", stall, 0);
    check_eq("reset_replay", replay, 0);
    check_eq("reset_wb_ena", wb_ena, 0);
    check_eq("reset_upd_ena", upd_ena, 0);
    check_eq("reset_mem_rd_req", mem_rd_req, 0);
    check_eq("reset_mem_wr_req", mem_wr_req, 0);
    check_eq("reset_mem_wr_valid", mem_wr_valid, 0);
    rst = 1'b0;

    run_miss(32'h0000_1234, 1'b0, 1'b0, 20'h00001, 1, -1,
             128'h00000044_00000033_00000022_00000011);
    run_miss(32'h5555_5238, 1'b1, 1'b1, 20'hABCDE, 1, -1, rand_line());
    run_miss(32'h7777_0ACC, 1'b0, 1'b1, 20'h13579, 2, -1, rand_line());
    run_hits(8);
    run_miss(32'h0000_4560, 1'b1, 1'b0, 20'h00004, 1, 2, rand_line());
    run_miss(32'h0000_9990, 1'b0, 1'b0, 20'h00009, 1, -1, rand_line());
    run_miss(32'h0000_9990, 1'b1, 1'b1, 20'h2468A, 1, -1, rand_line());
    run_miss(32'hFFFF_FFFC, 1'b0, 1'b1, 20'hFFFFF, 0, -1, rand_line());

    for (int t = 0; t < 30; t++) begin
      if ($urandom % 3 == 0) run_hits(1 + int'($urandom % 3));
      run_miss($urandom, 1'($urandom), 1'($urandom), 20'($urandom), 0, -1, rand_line());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
